fork_cond_nch_2ph: RTL and testbench
====================================

Name: fork_cond_nch_2ph

Overview:
- Parametrised successor to the two-channel conditional fork.
- Clocked, two-phase (transition-signalling) bundled-data fork with NCH output channels and a WIDTH-bit data bundle.
- Each input token carries a per-channel condition mask. The token's request is propagated only to channels whose mask bit is 1. The input ack toggles only after every selected channel has acknowledged.
- Sits between a synchronous producer and up to NCH consumers in the single-rail 2-phase library. All handshake signals are synchronous to clk; the block contains no synchronisers.

Parameters:
- WIDTH, 8, data bundle width in bits (>=1).
- NCH, 4, number of output channels (2..16).
- TIMEOUT_CYCLES, 1024, BUSY-state watchdog limit; used only with FORK_TIMEOUT_EN (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_req  in  1  input request; a toggle denotes a new token.
- in_ack  out  1  input acknowledge; registered toggle.
- in_data  in  WIDTH  input data; stable while in_req != in_ack.
- in_cond  in  NCH  per-channel propagate mask; bit i = 1 propagates to channel i. Stable with in_data.
- out_req  out  NCH  per-channel request toggles; registered.
- out_ack  in  NCH  per-channel acknowledge toggles.
- out_data  out  WIDTH  registered data shared by all channels.
- err  out  1  sticky watchdog flag; tied to 0 when the watchdog is compiled out.

Behaviour:
- Reset (asynchronous, rst=1):
  - in_ack=0, out_req=0, out_data=0, err=0.
  - Internal sel mask=0, state=IDLE, watchdog count=0.
  - Takes effect immediately. Any token in flight is discarded, with no completion ack.
- Pending input: pend = in_req ^ in_ack. It is sampled only in IDLE.
- IDLE, pend=1, in_cond!=0, at the next edge:
  - out_data<=in_data; sel<=in_cond.
  - out_req[i] toggles for each i with in_cond[i]=1.
  - state<=BUSY.
- IDLE, pend=1, in_cond==0, at the next edge:
  - in_ack toggles; state stays IDLE.
  - out_req and out_data are unchanged. The token is consumed in 1 cycle.
- IDLE, pend=0: hold all outputs.
- BUSY completion condition: done = AND over i of (~sel[i] | (out_ack[i]==out_req[i])).
- BUSY, done=1, at the next edge: in_ack toggles; sel<=0; state<=IDLE.
- BUSY, done=0: hold. out_data is guaranteed stable for the whole of BUSY.
- Unselected channels:
  - Their out_ack transitions are ignored in all states.
  - Their out_req never toggles for this token.
- Latency and throughput:
  - in_req toggle to out_req toggle: 1 cycle.
  - Final selected out_ack toggle to in_ack toggle: 1 cycle.
  - A new token is accepted in the cycle after in_ack toggles (IDLE re-entry). Maximum throughput is 1 token per 2 cycles with zero-delay consumers.
- Simultaneous events:
  - All selected acks arriving in the same cycle are handled as normal.
  - in_req toggling again while BUSY violates the producer's protocol. It is not sampled until IDLE.
- Protocol violations on a selected channel (a second ack toggle before a new req) are not detected. Behaviour is undefined beyond that channel's handshake.
- Phases:
  - All req/ack comparisons are phase-based (equality), never level-based.
  - Toggle counters wrap naturally as 1-bit values.

Optional Feature:
- Macro: FORK_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle, saturating at TIMEOUT_CYCLES.
  - When the counter reaches TIMEOUT_CYCLES while done=0, err<=1 at the next edge.
  - err stays high until rst, and the transaction continues normally.
- When undefined: no counter is instantiated and err is constant 0.

Test Plan:
- Reset, then a single token: in_req 0->1, in_data=8'hA5, in_cond=4'b0101.
  - out_req=4'b0101 and out_data=A5 one cycle later.
  - Toggle out_ack[0] and out_ack[2] together: in_ack=1 one cycle later. out_req[1], out_req[3] stay 0.
- Staggered acks, in_cond=4'b1111: ack channels 3,0,2,1 on separate cycles.
  - in_ack toggles exactly 1 cycle after the channel-1 ack, not earlier.
  - out_data is stable throughout.
- Empty mask: in_cond=0 with an in_req toggle.
  - in_ack toggles after 1 cycle. out_req and out_data are unchanged.
- Spurious ack: toggle out_ack[1] while sel=4'b0001.
  - No effect. Completion still waits for out_ack[0].
- Back-to-back tokens: 3 tokens with alternating masks 4'b0011 / 4'b1100.
  - Phases alternate correctly and in_ack ends at 1.
  - Then assert rst mid-BUSY: all outputs are 0 immediately.
- FORK_TIMEOUT_EN with TIMEOUT_CYCLES=8: withhold a selected ack.
  - err=1 after 8 BUSY cycles.
  - Then supply the ack: in_ack toggles and err stays 1 until rst.

Source files
------------

// File: rtl/fork_cond_nch_2ph.sv
// Two-phase bundled-data conditional fork with NCH output channels.
// Define FORK_TIMEOUT_EN to build the BUSY-state watchdog that drives err.
module fork_cond_nch_2ph #(
  parameter int WIDTH          = 8,
  parameter int NCH            = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  input  logic [NCH-1:0]   in_cond,
  output logic [NCH-1:0]   out_req,
  input  logic [NCH-1:0]   out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [NCH-1:0]   sel, sel_nxt;
  logic [NCH-1:0]   out_req_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             in_ack_nxt;
  logic             pend;
  logic             done;

  // A channel is finished when its ack phase has caught up with its req phase;
  // channels outside the latched mask count as finished.
  assign pend = in_req ^ in_ack;
  assign done = &(~sel | ~(out_ack ^ out_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      in_ack   <= 1'b0;
      out_req  <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      in_ack   <= in_ack_nxt;
      out_req  <= out_req_nxt;
      out_data <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    in_ack_nxt   = in_ack;
    out_req_nxt  = out_req;
    out_data_nxt = out_data;
    case (state)
      IDLE: begin
        if (pend) begin
          if (|in_cond) begin
            out_data_nxt = in_data;
            sel_nxt      = in_cond;
            out_req_nxt  = out_req ^ in_cond;
            state_nxt    = BUSY;
          end else begin
            // Empty mask: nobody to wait for, retire the token directly.
            in_ack_nxt = ~in_ack;
          end
        end
      end
      BUSY: begin
        if (done) begin
          in_ack_nxt = ~in_ack;
          sel_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FORK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Count is held at zero in IDLE so it always starts from zero on BUSY entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TMAX) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if ((state == BUSY) && (wd_cnt == TMAX) && !done) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fork_cond_nch_2ph.sv
// Directed self-checking bench for fork_cond_nch_2ph (WIDTH=8, NCH=4).
// With FORK_TIMEOUT_EN defined it also exercises the watchdog (TIMEOUT_CYCLES=8).
module tb_fork_cond_nch_2ph;

  logic       clk;
  logic       rst;
  logic       in_req;
  logic       in_ack;
  logic [7:0] in_data;
  logic [3:0] in_cond;
  logic [3:0] out_req;
  logic [3:0] out_ack;
  logic [7:0] out_data;
  logic       err;

  int total;
  int bad;

  fork_cond_nch_2ph #(
    .WIDTH(8),
    .NCH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_req(in_req),
    .in_ack(in_ack),
    .in_data(in_data),
    .in_cond(in_cond),
    .out_req(out_req),
    .out_ack(out_ack),
    .out_data(out_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic req, input logic [7:0] data, input logic [3:0] cond);
    in_req  = req;
    in_data = data;
    in_cond = cond;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ack, input logic [3:0] req, input logic [7:0] data);
    checkOutput({tag, ".in_ack"}, 32'(in_ack), 32'(ack));
    checkOutput({tag, ".out_req"}, 32'(out_req), 32'(req));
    checkOutput({tag, ".out_data"}, 32'(out_data), 32'(data));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    out_ack = 4'b0000;
    applyStimulus(1'b0, 8'h00, 4'b0000);
    #1 rst = 1'b1;
    #1;
    checkAll("reset", 1'b0, 4'b0000, 8'h00);
    checkOutput("reset.err", 32'(err), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    checkAll("idle_after_reset", 1'b0, 4'b0000, 8'h00);

    $display("[TB] single token, mask 0101");
    applyStimulus(1'b1, 8'hA5, 4'b0101);
    step();
    checkAll("t1.issue", 1'b0, 4'b0101, 8'hA5);
    out_ack = 4'b0101;
    step();
    checkAll("t1.done", 1'b1, 4'b0101, 8'hA5);

    $display("[TB] staggered acks, mask 1111");
    applyStimulus(1'b0, 8'h3C, 4'b1111);
    step();
    checkAll("t2.issue", 1'b1, 4'b1010, 8'h3C);
    out_ack = 4'b1101;
    step();
    checkAll("t2.ack3", 1'b1, 4'b1010, 8'h3C);
    out_ack = 4'b1100;
    step();
    checkAll("t2.ack0", 1'b1, 4'b1010, 8'h3C);
    out_ack = 4'b1000;
    step();
    checkAll("t2.ack2", 1'b1, 4'b1010, 8'h3C);
    out_ack = 4'b1010;
    step();
    checkAll("t2.ack1", 1'b0, 4'b1010, 8'h3C);

    $display("[TB] empty mask");
    applyStimulus(1'b1, 8'hFF, 4'b0000);
    step();
    checkAll("t3.consume", 1'b1, 4'b1010, 8'h3C);
    step();
    checkAll("t3.hold", 1'b1, 4'b1010, 8'h3C);

    $display("[TB] spurious ack on unselected channel");
    applyStimulus(1'b0, 8'h11, 4'b0001);
    step();
    checkAll("t4.issue", 1'b1, 4'b1011, 8'h11);
    out_ack = 4'b1000;
    step();
    checkAll("t4.spurious", 1'b1, 4'b1011, 8'h11);
    step();
    checkAll("t4.wait", 1'b1, 4'b1011, 8'h11);
    out_ack = 4'b1001;
    step();
    checkAll("t4.done", 1'b0, 4'b1011, 8'h11);
    out_ack = 4'b1011;
    step();
    checkAll("t4.idle_spurious", 1'b0, 4'b1011, 8'h11);

    $display("[TB] back-to-back tokens");
    applyStimulus(1'b1, 8'h01, 4'b0011);
    step();
    checkAll("t5a.issue", 1'b0, 4'b1000, 8'h01);
    out_ack = 4'b1000;
    step();
    checkAll("t5a.done", 1'b1, 4'b1000, 8'h01);
    applyStimulus(1'b0, 8'h02, 4'b1100);
    step();
    checkAll("t5b.issue", 1'b1, 4'b0100, 8'h02);
    out_ack = 4'b0100;
    step();
    checkAll("t5b.done", 1'b0, 4'b0100, 8'h02);
    applyStimulus(1'b1, 8'h03, 4'b0011);
    step();
    checkAll("t5c.issue", 1'b0, 4'b0111, 8'h03);
    out_ack = 4'b0111;
    step();
    checkAll("t5c.done", 1'b1, 4'b0111, 8'h03);

    $display("[TB] reset while busy");
    applyStimulus(1'b0, 8'h44, 4'b1111);
    step();
    checkAll("t5d.issue", 1'b1, 4'b1000, 8'h44);
    rst = 1'b1;
    #1;
    checkAll("t5d.reset", 1'b0, 4'b0000, 8'h00);
    checkOutput("t5d.reset.err", 32'(err), 32'd0);
    applyStimulus(1'b0, 8'h00, 4'b0000);
    out_ack = 4'b0000;
    step();
    rst = 1'b0;
    step();
    checkAll("t5d.idle", 1'b0, 4'b0000, 8'h00);

`ifdef FORK_TIMEOUT_EN
    $display("[TB] watchdog, TIMEOUT_CYCLES=8");
    applyStimulus(1'b1, 8'h77, 4'b0001);
    step();
    checkAll("t6.issue", 1'b0, 4'b0001, 8'h77);
    for (int i = 0; i < 8; i++) step();
    checkOutput("t6.err_before", 32'(err), 32'd0);
    step();
    checkOutput("t6.err_set", 32'(err), 32'd1);
    out_ack = 4'b0001;
    step();
    checkAll("t6.done", 1'b1, 4'b0001, 8'h77);
    checkOutput("t6.err_sticky", 32'(err), 32'd1);
    step();
    checkOutput("t6.err_sticky2", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6.err_reset", 32'(err), 32'd0);
    step();
    rst = 1'b0;
`else
    $display("[TB] long stall, err must stay low");
    applyStimulus(1'b1, 8'h77, 4'b0001);
    step();
    checkAll("t6.issue", 1'b0, 4'b0001, 8'h77);
    for (int i = 0; i < 12; i++) step();
    checkOutput("t6.err_low", 32'(err), 32'd0);
    checkAll("t6.stall", 1'b0, 4'b0001, 8'h77);
    out_ack = 4'b0001;
    step();
    checkAll("t6.done", 1'b1, 4'b0001, 8'h77);
    checkOutput("t6.err_low2", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
